// File: rtl/ring_vco_fcnt_pkg.sv
// Shared types and default constants for the ring VCO frequency counter.
// The state encoding is shared by the top module and the bench.
package ring_vco_pkg;

  typedef enum logic [2:0] {
    IDLE,
    KICK,
    SETTLE,
    MEASURE,
    REPORT
  } state_t;

  localparam int CNT_W_DEF         = 16;
  localparam int GATE_CYCLES_DEF   = 1024;
  localparam int KICK_CYCLES_DEF   = 8;
  localparam int SETTLE_CYCLES_DEF = 64;
  localparam int SYNC_STAGES_DEF   = 2;

  // Consecutive empty windows tolerated before a stall is reported.
  localparam int STALL_LIMIT = 4;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/ring_vco_fcnt_if.sv
// Result handshake between the frequency counter and the tuning/readout logic.
// The stall flag exists only when RING_VCO_FCNT_STALL_EN is defined.
interface ring_vco_fcnt_if import ring_vco_pkg::*; #(
  parameter int CNT_W = CNT_W_DEF
);
  logic [CNT_W-1:0] count;
  logic             count_valid;
  logic             count_ready;
  logic             overflow;
`ifdef RING_VCO_FCNT_STALL_EN
  logic             stall;

  modport master (output count, count_valid, overflow, stall, input count_ready);
  modport slave  (input count, count_valid, overflow, stall, output count_ready);
`else
  modport master (output count, count_valid, overflow, input count_ready);
  modport slave  (input count, count_valid, overflow, output count_ready);
`endif
endinterface

// File: rtl/ring_vco_edge_sync.sv
// Brings the asynchronous VCO output into the clk domain and emits a
// one-cycle pulse for each rising edge.
module ring_vco_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic osc_async,
  output logic rise
);
  logic [SYNC_STAGES-1:0] sync;
  logic                   sync_q_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync     <= '0;
      sync_q_d <= 1'b0;
    end else begin
      sync     <= {sync[SYNC_STAGES-2:0], osc_async};
      sync_q_d <= sync[SYNC_STAGES-1];
    end
  end

  assign rise = sync[SYNC_STAGES-1] & ~sync_q_d;
endmodule

// File: rtl/ring_vco_fcnt.sv
// Ring VCO kick-start sequencer and gated edge counter with valid/ready output.
// Define RING_VCO_FCNT_STALL_EN to re-kick on empty windows and flag a stall.
//
// state   | meaning
// IDLE    | waiting for start
// KICK    | vinit_n held low to start the oscillator
// SETTLE  | oscillator settling, nothing counted
// MEASURE | counting osc rising edges over the gate window
// REPORT  | result presented, waiting for count_ready
module ring_vco_fcnt import ring_vco_pkg::*; #(
  parameter int CNT_W         = CNT_W_DEF,
  parameter int GATE_CYCLES   = GATE_CYCLES_DEF,
  parameter int KICK_CYCLES   = KICK_CYCLES_DEF,
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF,
  parameter int SYNC_STAGES   = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic continuous,
  input  logic stop,
  input  logic osc_async,
  output logic vinit_n,
  output logic busy,
  ring_vco_fcnt_if.master res
);
  localparam int TMR_W = $clog2(max3(GATE_CYCLES, KICK_CYCLES, SETTLE_CYCLES));
  localparam logic [TMR_W-1:0] KICK_LD   = TMR_W'(KICK_CYCLES - 1);
  localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] GATE_LD   = TMR_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_t           state, state_nxt;
  logic [TMR_W-1:0] timer, timer_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
  logic [CNT_W-1:0] count_q, count_nxt;
  logic             win_ovf, win_ovf_nxt, ovf_inc;
  logic             ovf_q, ovf_nxt;
  logic             cont_q, cont_nxt;
  logic             stop_q, stop_nxt, stop_seen;
  logic             vinit_q, busy_q, valid_q;
  logic             rise, tmr_done;
`ifdef RING_VCO_FCNT_STALL_EN
  logic [2:0]       stall_cnt, stall_cnt_nxt;
  logic             stall_q, stall_nxt;
`endif

  ring_vco_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_edge_sync (
    .clk       (clk),
    .rst       (rst),
    .osc_async (osc_async),
    .rise      (rise)
  );

  assign tmr_done  = (timer == '0);
  assign stop_seen = stop_q | stop;
  // Edge on the window's last cycle is still folded into the reported count.
  assign cnt_inc   = (rise && (cnt != CNT_MAX)) ? cnt + CNT_W'(1) : cnt;
  assign ovf_inc   = win_ovf | (rise & (cnt == CNT_MAX));

  always_comb begin
    state_nxt   = state;
    timer_nxt   = tmr_done ? timer : timer - TMR_W'(1);
    cnt_nxt     = cnt;
    win_ovf_nxt = win_ovf;
    count_nxt   = count_q;
    ovf_nxt     = ovf_q;
    cont_nxt    = cont_q;
    stop_nxt    = stop_q;
`ifdef RING_VCO_FCNT_STALL_EN
    stall_cnt_nxt = stall_cnt;
    stall_nxt     = stall_q;
`endif
    case (state)
      IDLE: begin
        stop_nxt = 1'b0;
        if (start && !stop) begin
          state_nxt = KICK;
          timer_nxt = KICK_LD;
          cont_nxt  = continuous;
`ifdef RING_VCO_FCNT_STALL_EN
          stall_cnt_nxt = '0;
`endif
        end
      end
      KICK: begin
        stop_nxt = stop_seen;
        if (stop_seen) begin
          state_nxt = IDLE;
        end else if (tmr_done) begin
          state_nxt = SETTLE;
          timer_nxt = SETTLE_LD;
        end
      end
      SETTLE: begin
        stop_nxt = stop_seen;
        if (stop_seen) begin
          state_nxt = IDLE;
        end else if (tmr_done) begin
          state_nxt   = MEASURE;
          timer_nxt   = GATE_LD;
          cnt_nxt     = '0;
          win_ovf_nxt = 1'b0;
        end
      end
      MEASURE: begin
        stop_nxt    = stop_seen;
        cnt_nxt     = cnt_inc;
        win_ovf_nxt = ovf_inc;
        if (tmr_done) begin
`ifdef RING_VCO_FCNT_STALL_EN
          if ((cnt_inc == '0) && (stall_cnt < 3'(STALL_LIMIT - 1))) begin
            state_nxt     = KICK;
            timer_nxt     = KICK_LD;
            stall_cnt_nxt = stall_cnt + 3'd1;
          end else begin
            state_nxt     = REPORT;
            count_nxt     = cnt_inc;
            ovf_nxt       = ovf_inc;
            stall_nxt     = (cnt_inc == '0);
            stall_cnt_nxt = '0;
          end
`else
          state_nxt = REPORT;
          count_nxt = cnt_inc;
          ovf_nxt   = ovf_inc;
`endif
        end
      end
      REPORT: begin
        stop_nxt = stop_seen;
        if (res.count_ready) begin
          if (cont_q && !stop_seen) begin
            state_nxt   = MEASURE;
            timer_nxt   = GATE_LD;
            cnt_nxt     = '0;
            win_ovf_nxt = 1'b0;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      timer   <= '0;
      cnt     <= '0;
      win_ovf <= 1'b0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      cont_q  <= 1'b0;
      stop_q  <= 1'b0;
      vinit_q <= 1'b1;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
`ifdef RING_VCO_FCNT_STALL_EN
      stall_cnt <= '0;
      stall_q   <= 1'b0;
`endif
    end else begin
      state   <= state_nxt;
      timer   <= timer_nxt;
      cnt     <= cnt_nxt;
      win_ovf <= win_ovf_nxt;
      count_q <= count_nxt;
      ovf_q   <= ovf_nxt;
      cont_q  <= cont_nxt;
      stop_q  <= stop_nxt;
      // Registered so the PMOS gate never sees state-decode glitches.
      vinit_q <= (state_nxt != KICK);
      busy_q  <= (state_nxt != IDLE);
      valid_q <= (state_nxt == REPORT);
`ifdef RING_VCO_FCNT_STALL_EN
      stall_cnt <= stall_cnt_nxt;
      stall_q   <= stall_nxt;
`endif
    end
  end

  assign vinit_n         = vinit_q;
  assign busy            = busy_q;
  assign res.count       = count_q;
  assign res.overflow    = ovf_q;
  assign res.count_valid = valid_q;
`ifdef RING_VCO_FCNT_STALL_EN
  assign res.stall       = stall_q;
`endif
endmodule

// File: tb/tb_ring_vco_fcnt.sv
// Bench for ring_vco_fcnt: vector table of osc periods scored through a result
// queue, plus hand-written kick, backpressure, abort, reset and overflow cases.
module tb_ring_vco_fcnt;
  import ring_vco_pkg::*;

  typedef struct {
    int lo;
    int hi;
    bit ovf;
    bit stall;
  } exp_t;

  typedef struct {
    int half_ns;
    int lo;
    int hi;
  } vec_t;

  logic clk, rst, start, continuous, stop, osc, start8;
  logic vinit_n, busy, vinit_n8, busy8;
  int   osc_half;
  int   n_tests, n_fail;
  exp_t sb[$];
  exp_t e;
  vec_t vecs[5];

  ring_vco_fcnt_if #(.CNT_W(16)) res ();
  ring_vco_fcnt_if #(.CNT_W(8))  res8 ();

  ring_vco_fcnt #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .continuous(continuous), .stop(stop),
    .osc_async(osc), .vinit_n(vinit_n), .busy(busy), .res(res)
  );

  ring_vco_fcnt #(.CNT_W(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .continuous(continuous), .stop(stop),
    .osc_async(osc), .vinit_n(vinit_n8), .busy(busy8), .res(res8)
  );

  assign res8.count_ready = 1'b1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Oscillator phase stays at 3 ns mod 5 so it never lands on a clk edge.
  initial begin
    osc = 1'b0;
    #3;
    forever begin
      if (osc_half == 0) #10 osc = osc;
      else #(osc_half) osc = ~osc;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_rng(input string name, input int act, input int lo, input int hi);
    n_tests++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Scoreboard: every accepted result is matched against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && res.count_valid && res.count_ready) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_result: got count %0d, expected no result", res.count);
      end else begin
        e = sb.pop_front();
        check_rng("result_count", int'(res.count), e.lo, e.hi);
        check("result_overflow", res.overflow, e.ovf);
`ifdef RING_VCO_FCNT_STALL_EN
        check("result_stall", res.stall, e.stall);
`endif
      end
    end
  end

  task automatic pulse_start(input logic cont);
    @(posedge clk); #2 start = 1'b1; continuous = cont;
    @(posedge clk); #2 start = 1'b0;
  endtask

  task automatic pulse_stop();
    @(posedge clk); #2 stop = 1'b1;
    @(posedge clk); #2 stop = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output int cyc, output int kick_cyc);
    cyc = 0;
    kick_cyc = 0;
    @(negedge clk);
    while (!res.count_valid && cyc < budget) begin
      if (!vinit_n) kick_cyc++;
      cyc++;
      @(negedge clk);
    end
    check("valid_within_budget", res.count_valid, 1'b1);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < budget) begin
      n++;
      @(negedge clk);
    end
    check("idle_within_budget", busy, 1'b0);
  endtask

`ifdef RING_VCO_FCNT_STALL_EN
  // Counts kick pulses until a result; starts the osc when pulse enable_at begins.
  task automatic run_kicks(input int enable_at, output int pulses);
    logic prev;
    int   n;
    pulses = 0;
    prev = 1'b1;
    n = 0;
    @(negedge clk);
    while (!res.count_valid && n < 6000) begin
      if (prev && !vinit_n) begin
        pulses++;
        if (pulses == enable_at) osc_half = 50;
      end
      prev = vinit_n;
      n++;
      @(negedge clk);
    end
    check("stall_valid_within_budget", res.count_valid, 1'b1);
  endtask
`endif

  initial begin
    int n, k, w, c0;
    n_tests = 0;
    n_fail = 0;
    osc_half = 0;
    start = 1'b0;
    start8 = 1'b0;
    continuous = 1'b0;
    stop = 1'b0;
    res.count_ready = 1'b1;

    vecs[0] = '{50, 102, 103};
    vecs[1] = '{100, 51, 52};
    vecs[2] = '{20, 256, 256};
    vecs[3] = '{15, 341, 342};
    vecs[4] = '{35, 146, 147};

    // Reset
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_vinit_n", vinit_n, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_valid", res.count_valid, 1'b0);
    check("rst_count", res.count, 0);
    check("rst_overflow", res.overflow, 1'b0);
    check("rst8_vinit_n", vinit_n8, 1'b1);
    check("rst8_valid", res8.count_valid, 1'b0);
    @(posedge clk); #2 rst = 1'b0;

    // Vector table: single windows at several osc periods
    for (int i = 0; i < 5; i++) begin
      osc_half = vecs[i].half_ns;
      sb.push_back('{vecs[i].lo, vecs[i].hi, 1'b0, 1'b0});
      pulse_start(1'b0);
      wait_idle(1300);
    end

    // Single measurement: kick length, settle+gate length, valid held
    res.count_ready = 1'b0;
    osc_half = 50;
    sb.push_back('{102, 103, 1'b0, 1'b0});
    pulse_start(1'b0);
    @(negedge clk);
    k = 0;
    while (!vinit_n && k < 20) begin
      k++;
      @(negedge clk);
    end
    check("kick_len", k, 8);
    n = 0;
    while (!res.count_valid && n < 1200) begin
      n++;
      @(negedge clk);
    end
    check("settle_plus_gate_len", n, 1088);
    c0 = res.count;
    repeat (20) @(negedge clk);
    check("held_count", res.count, c0);
    check("held_valid", res.count_valid, 1'b1);
    @(posedge clk); #2 res.count_ready = 1'b1;
    wait_idle(10);
    check("single_vinit_n_idle", vinit_n, 1'b1);

    // Continuous with backpressure, then stop
    res.count_ready = 1'b0;
    sb.push_back('{102, 103, 1'b0, 1'b0});
    sb.push_back('{102, 103, 1'b0, 1'b0});
    pulse_start(1'b1);
    wait_valid(1300, n, k);
    check("cont_first_kick", k, 8);
    c0 = res.count;
    repeat (50) @(negedge clk);
    check("bp_count_stable", res.count, c0);
    check("bp_valid_held", res.count_valid, 1'b1);
    @(posedge clk); #2 res.count_ready = 1'b1;
    @(posedge clk); #2 res.count_ready = 1'b0;
    pulse_stop();
    @(negedge clk);
    check("cont_busy_after_stop", busy, 1'b1);
    wait_valid(1300, n, k);
    check("cont_no_rekick", k, 0);
    @(posedge clk); #2 res.count_ready = 1'b1;
    wait_idle(10);

    // Back-to-back windows with ready held high
    sb.push_back('{102, 103, 1'b0, 1'b0});
    sb.push_back('{102, 103, 1'b0, 1'b0});
    sb.push_back('{102, 103, 1'b0, 1'b0});
    pulse_start(1'b1);
    wait_valid(1300, n, k);
    w = 0;
    while (res.count_valid && w < 5) begin
      w++;
      @(negedge clk);
    end
    check("b2b_valid_width", w, 1);
    n = 0;
    while (!res.count_valid && n < 1100) begin
      n++;
      @(negedge clk);
    end
    check("b2b_gap", n, 1024);
    pulse_stop();
    wait_idle(1300);

    // start and stop in the same IDLE cycle
    @(posedge clk); #2 start = 1'b1; stop = 1'b1; continuous = 1'b0;
    @(posedge clk); #2 start = 1'b0; stop = 1'b0;
    @(negedge clk);
    check("start_stop_same_cycle", busy, 1'b0);

    // Abort during SETTLE
    pulse_start(1'b0);
    @(negedge clk);
    k = 0;
    while (!vinit_n && k < 20) begin
      k++;
      @(negedge clk);
    end
    repeat (10) @(negedge clk);
    pulse_stop();
    @(negedge clk);
    check("abort_busy", busy, 1'b0);
    repeat (20) @(negedge clk);
    check("abort_no_valid", res.count_valid, 1'b0);

    // Reset during MEASURE
    res.count_ready = 1'b0;
    pulse_start(1'b0);
    repeat (300) @(negedge clk);
    check("pre_rst_busy", busy, 1'b1);
    @(posedge clk); #2 rst = 1'b1;
    @(posedge clk); #2 rst = 1'b0;
    @(negedge clk);
    check("mid_rst_vinit_n", vinit_n, 1'b1);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_valid", res.count_valid, 1'b0);
    check("mid_rst_count", res.count, 0);
    check("mid_rst_overflow", res.overflow, 1'b0);
    res.count_ready = 1'b1;

    // Overflow on the 8-bit instance, osc period 3 clk
    osc_half = 15;
    @(posedge clk); #2 start8 = 1'b1; continuous = 1'b0;
    @(posedge clk); #2 start8 = 1'b0;
    n = 0;
    @(negedge clk);
    while (!res8.count_valid && n < 1300) begin
      n++;
      @(negedge clk);
    end
    check("ovf8_valid", res8.count_valid, 1'b1);
    check("ovf8_count", res8.count, 255);
    check("ovf8_flag", res8.overflow, 1'b1);
    repeat (3) @(negedge clk);
    check("ovf8_idle", busy8, 1'b0);

    // Static osc: empty windows
    osc_half = 0;
`ifdef RING_VCO_FCNT_STALL_EN
    sb.push_back('{0, 0, 1'b0, 1'b1});
    pulse_start(1'b0);
    run_kicks(0, k);
    check("stall_kick_pulses", k, 4);
    wait_idle(10);
    sb.push_back('{102, 103, 1'b0, 1'b0});
    pulse_start(1'b0);
    run_kicks(3, k);
    check("recover_kick_pulses", k, 3);
    wait_idle(10);
`else
    sb.push_back('{0, 0, 1'b0, 1'b0});
    pulse_start(1'b0);
    wait_valid(1300, n, k);
    check("zero_window_kick", k, 8);
    wait_idle(10);
`endif

    check("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ring_vco_fcnt.md
Name: ring_vco_fcnt

Overview:
Digital frequency counter and start-up sequencer that sits directly downstream of the ring VCO.
- Drives the VCO's vinit kick-start input, then counts rising edges of the VCO osc output over a fixed window of reference clocks.
- Delivers each count over a valid/ready handshake to the tuning/readout logic.
- osc is asynchronous to clk; the block synchronises it internally.
- Measured osc frequency must be below f_clk/2.

Parameters:
- CNT_W, 16, width of edge count result.
- GATE_CYCLES, 1024, measurement window length in clk cycles (>=2).
- KICK_CYCLES, 8, cycles vinit_n is held low at start-up (>=1).
- SETTLE_CYCLES, 64, wait after kick before first window (>=1).
- SYNC_STAGES, 2, flops in osc synchroniser (>=2).

Ports:
- clk  input  1  reference clock
- rst  input  1  synchronous active-high reset
- start  input  1  single-cycle request to begin a sequence; ignored unless IDLE
- continuous  input  1  sampled at start; 1 = repeat windows until stop
- stop  input  1  return to IDLE after current window's result is accepted
- osc_async  input  1  VCO osc output, asynchronous
- vinit_n  output  1  VCO kick-start gate, active low (drives PMOS gate)
- busy  output  1  high in any state other than IDLE
- count  output  CNT_W  edges counted in last window
- count_valid  output  1  count holds a new result
- count_ready  input  1  consumer accepts count
- overflow  output  1  edge counter saturated in the reported window

Behaviour:
- Reset values:
  - vinit_n=1, busy=0, count=0, count_valid=0, overflow=0.
  - State IDLE; synchroniser flops cleared.
- Synchroniser and edge detect:
  - osc_async passes through SYNC_STAGES flops.
  - A rising edge is sync_q & ~sync_q_d, one further flop.
  - Edge latency from osc_async to counter increment is SYNC_STAGES+1 cycles.
- State machine:
  - IDLE: start=1 -> KICK, latch continuous, load timer=KICK_CYCLES-1.
  - KICK: vinit_n=0. Timer reaches 0 -> SETTLE, timer=SETTLE_CYCLES-1. vinit_n returns to 1 on the cycle SETTLE is entered.
  - SETTLE: timer reaches 0 -> MEASURE, timer=GATE_CYCLES-1, edge counter cleared.
  - MEASURE: each detected edge increments the counter, saturating at 2^CNT_W-1 and setting the sticky window overflow flag. Timer reaches 0 -> REPORT. The final cycle's edge is included, so the window is exactly GATE_CYCLES cycles.
  - REPORT: count/overflow are loaded and count_valid=1, held stable until count_ready. On the handshake, count_valid drops next cycle. Then:
    - continuous=1 and stop not seen -> MEASURE (counter cleared, timer reloaded; no re-kick);
    - otherwise -> IDLE.
- stop is sticky from any non-IDLE state until the sequence ends. stop in KICK/SETTLE aborts immediately to IDLE with no result.
- Back-to-back windows lose no more than 1 cycle per handshake: count_ready held high gives a REPORT duration of 1 cycle.
- start while busy is ignored. start and stop in the same IDLE cycle: stop wins, stay IDLE.
- rst mid-operation: immediate return to reset values on next edge. Any pending count is discarded.
- count/overflow only change on entry to REPORT.

Optional Feature:
- Macro RING_VCO_FCNT_STALL_EN.
- When defined:
  - In MEASURE, a window ending with count==0 does not report. It returns to KICK (re-kick) and increments a 3-bit stall counter.
  - After 4 consecutive zero windows, REPORT with count=0 and an extra output stall=1.
  - The stall counter clears on any non-zero window.
- When undefined:
  - A zero window reports count=0 normally.
  - The stall port is absent.

Decomposition:
- Package ring_vco_pkg holds:
  - the state enum (IDLE, KICK, SETTLE, MEASURE, REPORT);
  - default parameter constants;
  - the stall limit constant (4).
- One sub-module: ring_vco_edge_sync (SYNC_STAGES synchroniser plus rising-edge pulse).
- Counter, timer and FSM stay in ring_vco_fcnt.

Test Plan:
- Reset: assert rst 3 cycles -> vinit_n=1, busy=0, count_valid=0, count=0.
- Single measurement, osc period 10 clk: start -> vinit_n low exactly 8 cycles, then 64 settle cycles -> count=102 or 103 (window 1024), overflow=0, valid held until ready.
- Backpressure and continuous: continuous=1, count_ready low 50 cycles -> count stable; after ready, next window starts with no re-kick; stop -> IDLE after that result is accepted.
- Overflow: CNT_W=8, osc period 3 clk -> count=255, overflow=1.
- Abort: stop during SETTLE -> IDLE next cycle, no count_valid; rst during MEASURE -> all outputs at reset values.
- STALL_EN: osc held constant -> 4 kick pulses observed, then count=0, stall=1; osc toggling on 3rd retry -> normal non-zero report, stall=0.
